// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side arbiter.
//   arb_state_t : sequencer states (IDLE, LAUNCH, WAIT_DONE)
//   UART_DATA_W : width of one UART byte
//   rr_next_idx : round-robin successor of an index, wrapping at n
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

  function automatic int rr_next_idx(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker. The search starts at (ptr + 1) mod N_REQ
// and wraps, so the requester at ptr has the lowest priority.
// Ports:
//   req     : request vector
//   ptr     : index of the last grant
//   gnt     : one-hot grant (all zero when no request)
//   gnt_idx : binary index of the grant
//   any     : at least one request present
module rr_arbiter
  import uart_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   gnt_idx,
  output logic             any
);

  int pos;

  // Walk the priority ring starting just after ptr; the first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    pos     = int'(ptr);
    for (int k = 0; k < N_REQ; k++) begin
      pos = rr_next_idx(pos, N_REQ);
      for (int i = 0; i < N_REQ; i++) begin
        if (!any && (i == pos) && req[i]) begin
          gnt[i]  = 1'b1;
          gnt_idx = IDW'(i);
          any     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between N_REQ byte producers with round-robin
// arbitration and sequences the start/busy handshake of the transmitter.
// Optional feature: define UART_ARB_TIMEOUT_EN to abandon a launch that
// never sees busy within TIMEOUT cycles (sets sticky err).
// Ports:
//   clk, srst_n : clock, asynchronous active-low reset
//   req_valid   : per-requester byte pending
//   req_data    : requester i byte at [8*i+7:8*i]
//   req_ready   : one-hot accept pulse (combinational from state and valids)
//   tx_start    : registered start strobe to uart_tx, held until busy seen
//   tx_data     : registered byte to uart_tx, stable while active
//   tx_busy     : uart_tx busy, asynchronous, synchronised here
//   grant_id    : index of current or last granted requester
//   active      : sequencer not in IDLE
//   err         : sticky launch timeout (0 unless UART_ARB_TIMEOUT_EN)
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int SYNC_STAGES = 2,
  parameter  int TIMEOUT     = 4096,
  localparam int IDW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         srst_n,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*UART_DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         tx_start,
  output logic [UART_DATA_W-1:0]       tx_data,
  input  logic                         tx_busy,
  output logic [IDW-1:0]               grant_id,
  output logic                         active,
  output logic                         err
);

  logic [N_REQ-1:0][UART_DATA_W-1:0] req_bytes;
  logic [SYNC_STAGES-1:0]            busy_sync;
  logic                              busy_s;
  arb_state_t                        state;
  logic [IDW-1:0]                    rr_ptr;
  logic [N_REQ-1:0]                  gnt;
  logic [IDW-1:0]                    gnt_idx;
  logic                              gnt_any;
  logic [UART_DATA_W-1:0]            win_byte;
  logic                              can_grant;

  assign req_bytes = req_data;

  // tx_busy synchroniser; busy_s is the last stage.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) busy_sync <= '0;
    else         busy_sync <= {busy_sync[SYNC_STAGES-2:0], tx_busy};
  end
  assign busy_s = busy_sync[SYNC_STAGES-1];

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // One-hot mux of the winning byte.
  always_comb begin
    win_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) win_byte = win_byte | req_bytes[i];
    end
  end

  // Gating with srst_n keeps req_ready low for the whole reset pulse even
  // though the state already reads IDLE.
  assign can_grant = (state == IDLE) && !busy_s;
  assign req_ready = (srst_n && can_grant) ? gnt : '0;
  assign active    = (state != IDLE);
  assign grant_id  = rr_ptr;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int             TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] to_cnt;
  logic          err_q;
  assign err = err_q;
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT > 0);
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      rr_ptr   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      to_cnt   <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (can_grant && gnt_any) begin
            tx_data  <= win_byte;
            rr_ptr   <= gnt_idx;
            tx_start <= 1'b1;
            state    <= LAUNCH;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt   <= '0;
`endif
          end
        end
        LAUNCH: begin
          if (busy_s) begin
            tx_start <= 1'b0;
            state    <= WAIT_DONE;
          end
`ifdef UART_ARB_TIMEOUT_EN
          // Byte is dropped; the pointer already moved past this requester.
          else if (to_cnt == TO_LAST) begin
            tx_start <= 1'b0;
            err_q    <= 1'b1;
            state    <= IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
`endif
        end
        WAIT_DONE: begin
          if (!busy_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: producers and a uart_tx busy model
// drive the DUT; a grant monitor predicts each winner from the round-robin
// rule and queues the expected byte; an output monitor pops and compares.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int SS  = 2;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             srst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*8-1:0]   req_data = '0;
  logic [N-1:0]     req_ready;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             tx_busy;
  logic [IDW-1:0]   grant_id;
  logic             active;
  logic             err;

  uart_tx_arbiter #(.N_REQ(N), .SYNC_STAGES(SS), .TIMEOUT(4096)) dut (
    .clk(clk), .srst_n(srst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .grant_id(grant_id), .active(active), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [7:0] data; } exp_t;

  int         checks = 0, failures = 0;
  logic [7:0] pq [N][$];
  bit [N-1:0] hold_off = '0;
  logic [N-1:0] rdy_neg = '0;
  int         pushed = 0, delivered = 0;
  int         model_ptr = 0;
  int         gnt_log[$];
  exp_t       expq[$];
  exp_t       cur;
  bit         have_cur = 0, act_prev = 0;
  int         epoch = 0;
  bit         mbusy = 0, ext_busy = 0, in_frame = 0;
  int         min_len = 2;

  assign tx_busy = mbusy | ext_busy;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    chk(act == req, name, act, req);
  endtask

  // Reference round-robin: first valid requester after the last grant.
  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (p + k) % N;
      for (int i = 0; i < N; i++) if (i == idx && v[i]) return i;
    end
    return -1;
  endfunction

  task automatic push(input int i, input logic [7:0] d);
    pq[i].push_back(d);
    pushed++;
  endtask

  // Producers: pop on handshake, present queue head otherwise.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (rdy_neg[i] && req_valid[i] && pq[i].size() > 0) void'(pq[i].pop_front());
      req_valid[i] = (pq[i].size() != 0) && !hold_off[i];
      req_data[8*i +: 8] = (pq[i].size() != 0) ? pq[i][0] : 8'h00;
    end
  end

  // Grant monitor: predicts the winner and queues the expected byte.
  always @(negedge clk) begin : mon_grant
    int w, ew;
    rdy_neg = req_ready;
    if (srst_n && req_ready != '0) begin
      w = -1;
      for (int i = 0; i < N; i++) if (req_ready[i]) w = i;
      ew = rr_pick(req_valid, model_ptr);
      chk($onehot(req_ready), "ready_onehot", req_ready, 32'h1);
      chk_eq("grant_winner", w, ew);
      chk_eq("ready_only_idle", active, 0);
      if (ew >= 0) begin
        expq.push_back('{ew, pq[ew][0]});
        model_ptr = ew;
      end
      gnt_log.push_back(w);
    end
  end

  // Output monitor: pops on each launch, checks data/id for the whole frame.
  always @(negedge clk) begin : mon_out
    if (!srst_n) begin
      act_prev = 0;
      have_cur = 0;
    end else begin
      if (active && !act_prev) begin
        if (expq.size() == 0) begin
          chk(0, "unexpected_launch", 1, 0);
          have_cur = 0;
        end else begin
          cur = expq.pop_front();
          have_cur = 1;
          delivered++;
        end
      end
      if (active && have_cur) begin
        chk_eq("tx_data", tx_data, cur.data);
        chk_eq("grant_id", grant_id, cur.id);
      end
      chk_eq("err_low", err, 0);
      act_prev = active;
    end
  end

  // uart_tx busy model with randomised response delay and frame length.
  initial begin : uart_model
    forever begin
      @(negedge clk);
      if (srst_n && tx_start && !in_frame) begin
        int ep, n, dly, len;
        in_frame = 1;
        ep = epoch;
        dly = $urandom_range(0, 3);
        repeat (dly) begin
          @(negedge clk);
          if (epoch == ep) chk_eq("tx_start_held", tx_start, 1);
        end
        @(posedge clk); #1 mbusy = 1;
        n = 0;
        while (n < SS + 4) begin
          @(negedge clk);
          if (!tx_start) break;
          n++;
        end
        // busy raised just after an edge: SS edges to busy_s, one more to the flop
        if (epoch == ep) chk(n >= SS && n <= SS + 1, "tx_start_drop_latency", n, SS + 1);
        len = $urandom_range(min_len, min_len + 14);
        repeat (len) @(posedge clk);
        #1 mbusy = 0;
        n = 0;
        while (n < SS + 4) begin
          @(negedge clk);
          if (!active) break;
          n++;
        end
        if (epoch == ep) chk(n >= SS && n <= SS + 1, "active_drop_latency", n, SS + 1);
        in_frame = 0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 srst_n = 0;
    epoch++;
    model_ptr = 0;
    expq.delete();
    gnt_log.delete();
    rdy_neg = '0;
    repeat (2) @(negedge clk);
    srst_n = 1;
  endtask

  task automatic wait_idle(input int max, input string name);
    bit ok;
    ok = 0;
    for (int c = 0; c < max && !ok; c++) begin
      @(negedge clk);
      if (req_valid == '0 && !active && !in_frame && !tx_busy && expq.size() == 0 &&
          pq[0].size() == 0 && pq[1].size() == 0 && pq[2].size() == 0 && pq[3].size() == 0)
        ok = 1;
    end
    chk(ok, name, 0, 1);
  endtask

  task automatic wait_grants(input int n, input int max, input string name);
    bit ok;
    ok = 0;
    for (int c = 0; c < max && !ok; c++) begin
      @(negedge clk);
      if (gnt_log.size() >= n) ok = 1;
    end
    chk(ok, name, gnt_log.size(), n);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int g0;
    bit ok;
    // Reset state
    #12;
    chk_eq("rst_req_ready", req_ready, 0);
    chk_eq("rst_tx_start", tx_start, 0);
    chk_eq("rst_tx_data", tx_data, 0);
    chk_eq("rst_grant_id", grant_id, 0);
    chk_eq("rst_active", active, 0);
    chk_eq("rst_err", err, 0);
    @(negedge clk);
    srst_n = 1;

    // Single requester 2
    @(negedge clk);
    push(2, 8'hA5);
    wait_idle(300, "a_idle");
    chk_eq("a_grants", gnt_log.size(), 1);
    chk_eq("a_first", gnt_log[0], 2);
    chk_eq("a_grant_id", grant_id, 2);
    chk_eq("a_tx_data", tx_data, 8'hA5);

    // All requesters valid after reset: 1,2,3,0,1
    do_reset();
    for (int i = 0; i < N; i++) push(i, 8'h10 + 8'(i));
    push(1, 8'h21);
    wait_idle(1000, "b_idle");
    chk_eq("b_grants", gnt_log.size(), 5);
    chk_eq("b_g0", gnt_log[0], 1);
    chk_eq("b_g1", gnt_log[1], 2);
    chk_eq("b_g2", gnt_log[2], 3);
    chk_eq("b_g3", gnt_log[3], 0);
    chk_eq("b_g4", gnt_log[4], 1);

    // External transfer in progress blocks grants
    ext_busy = 1;
    repeat (4) @(negedge clk);
    g0 = gnt_log.size();
    push(0, 8'h5C);
    repeat (12) @(negedge clk);
    chk_eq("c_no_grant_while_busy", gnt_log.size(), g0);
    ext_busy = 0;
    wait_idle(300, "c_idle");
    chk_eq("c_grants", gnt_log.size(), g0 + 1);
    chk_eq("c_winner", gnt_log[g0], 0);

    // Reset during WAIT_DONE with a competing request pending
    min_len = 30;
    @(negedge clk);
    push(2, 8'h3C);
    ok = 0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (mbusy && active && !tx_start) ok = 1;
    end
    chk(ok, "d_reach_wait_done", 0, 1);
    push(1, 8'hC3);
    repeat (2) @(negedge clk);
    #2 srst_n = 0;
    epoch++;
    #1;
    chk_eq("d_tx_start", tx_start, 0);
    chk_eq("d_active", active, 0);
    chk_eq("d_req_ready", req_ready, 0);
    chk_eq("d_grant_id", grant_id, 0);
    model_ptr = 0;
    expq.delete();
    gnt_log.delete();
    rdy_neg = '0;
    repeat (3) @(negedge clk);
    srst_n = 1;
    min_len = 2;
    wait_idle(400, "d_idle");
    chk_eq("d_grants", gnt_log.size(), 1);
    chk_eq("d_winner", gnt_log[0], 1);

    // Requester 3 withdraws while 0 is served
    do_reset();
    min_len = 10;
    push(0, 8'h70);
    push(0, 8'h71);
    wait_grants(1, 200, "e_first_grant");
    push(3, 8'h73);
    repeat (3) @(negedge clk);
    hold_off[3] = 1;
    wait_grants(2, 400, "e_second_grant");
    repeat (2) @(negedge clk);
    hold_off[3] = 0;
    min_len = 2;
    wait_idle(400, "e_idle");
    chk_eq("e_grants", gnt_log.size(), 3);
    chk_eq("e_g0", gnt_log[0], 0);
    chk_eq("e_g1_skips_3", gnt_log[1], 0);
    chk_eq("e_g2", gnt_log[2], 3);

    // Randomised traffic with withdrawals
    for (int c = 0; c < 600; c++) begin
      int i;
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        i = $urandom_range(0, N - 1);
        if (pq[i].size() < 3) push(i, 8'($urandom));
      end
      if ($urandom_range(0, 15) == 0) begin
        i = $urandom_range(0, N - 1);
        hold_off[i] = ~hold_off[i];
      end
    end
    hold_off = '0;
    wait_idle(20000, "r_idle");
    chk_eq("bytes_delivered", delivered, pushed);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
